// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI3 bridge.
//   - Read and write FSM state encodings.
//   - Default AXI IDs for instruction and data traffic.
//   - Fixed AXI size/burst/length constants and the SRAM-size to AXI-size mapping.
// Optional feature macro used by the bridge: SRAM_AXI_BRIDGE_RR_EN (round-robin reads).
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  // Which requester won the last read arbitration (round-robin build only).
  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  localparam logic [3:0] ID_INST_DEF    = 4'd0;
  localparam logic [3:0] ID_DATA_DEF    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  // SRAM size (bytes = 2**size) maps directly onto the low bits of AXI size.
  function automatic logic [2:0] to_axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_chk.sv
// Protocol checker for the bridge: a load return and a store completion must
// never land on the data port in the same cycle.
// Ports: clk_i, reset_i, rd_data_ok_i (load return), wr_data_ok_i (store B).
module sram_axi_bridge_chk (
  input logic clk_i,
  input logic reset_i,
  input logic rd_data_ok_i,
  input logic wr_data_ok_i
);

  a_single_data_completion: assert property (
    @(posedge clk_i) disable iff (reset_i) !(rd_data_ok_i && wr_data_ok_i)
  );

endmodule

// File: rtl/sram_axi_rd_arb.sv
// Read arbiter and read-channel FSM for the SRAM-to-AXI3 bridge.
// Accepts one read at a time from either the fetch or the load requester,
// issues it on AR, waits for the single R beat and routes the completion
// pulse back by the latched ID.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   inst_req_i/size_i/addr_i        fetch request
//   data_req_i/size_i/addr_i        load request (stores are filtered out by the top)
//   raw_block_i                     load blocked by a pending store to the same word
//   inst_addr_ok_o, data_addr_ok_o  combinational accept pulses
//   arid_o/araddr_o/arsize_o/arvalid_o, arready_i   AR channel
//   rvalid_i, rready_o              R channel handshake
//   inst_data_ok_o, data_data_ok_o  return pulses, routed by latched ID
// Macro SRAM_AXI_BRIDGE_RR_EN selects round-robin arbitration; otherwise loads
// have fixed priority over fetches.
module sram_axi_rd_arb
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inst_req_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic        data_req_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic        raw_block_i,
  output logic        inst_addr_ok_o,
  output logic        data_addr_ok_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [2:0]  arsize_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic        inst_data_ok_o,
  output logic        data_data_ok_o
);

  rd_state_e   state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;

  logic        data_cand_s, inst_cand_s;
  logic        grant_data_s, grant_inst_s;
  logic        idle_s, accept_data_s, accept_inst_s;

`ifdef SRAM_AXI_BRIDGE_RR_EN
  grant_e      last_grant_q;
`endif

  // Arbitration between the two read requesters.
  always_comb begin
    data_cand_s = data_req_i & ~raw_block_i & ~reset_i;
    inst_cand_s = inst_req_i & ~reset_i;
`ifdef SRAM_AXI_BRIDGE_RR_EN
    // On contention the requester that did not win last time goes first.
    if (data_cand_s && inst_cand_s) begin
      grant_data_s = (last_grant_q == GRANT_INST);
    end else begin
      grant_data_s = data_cand_s;
    end
`else
    grant_data_s = data_cand_s;
`endif
    grant_inst_s  = inst_cand_s & ~grant_data_s;
    idle_s        = (state_q == R_IDLE);
    accept_data_s = idle_s & grant_data_s;
    accept_inst_s = idle_s & grant_inst_s;
  end

`ifdef SRAM_AXI_BRIDGE_RR_EN
  // Remember the most recent read winner.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= GRANT_INST;
    end else if (accept_data_s) begin
      last_grant_q <= GRANT_DATA;
    end else if (accept_inst_s) begin
      last_grant_q <= GRANT_INST;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end
`endif

  // Read FSM state and latched request registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= R_IDLE;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  // Read FSM next state; the request is latched in the accept cycle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    size_d  = size_q;
    case (state_q)
      R_IDLE: begin
        if (accept_data_s) begin
          state_d = R_AR;
          id_d    = ID_DATA;
          addr_d  = data_addr_i;
          size_d  = to_axi_size(data_size_i);
        end else if (accept_inst_s) begin
          state_d = R_AR;
          id_d    = ID_INST;
          addr_d  = inst_addr_i;
          size_d  = to_axi_size(inst_size_i);
        end else begin
          state_d = R_IDLE;
        end
      end
      R_AR: begin
        if (arready_i) begin
          state_d = R_R;
        end else begin
          state_d = R_AR;
        end
      end
      R_R: begin
        if (rvalid_i) begin
          state_d = R_IDLE;
        end else begin
          state_d = R_R;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read-channel outputs and return routing.
  always_comb begin
    arvalid_o      = (state_q == R_AR);
    rready_o       = (state_q == R_R);
    arid_o         = id_q;
    araddr_o       = addr_q;
    arsize_o       = size_q;
    inst_addr_ok_o = accept_inst_s;
    data_addr_ok_o = accept_data_s;
    inst_data_ok_o = rvalid_i & rready_o & ~reset_i & (id_q == ID_INST);
    data_data_ok_o = rvalid_i & rready_o & ~reset_i & (id_q == ID_DATA);
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// SRAM-like (instruction + data) to single AXI3 master bridge.
// One outstanding read (fetch or load) and one outstanding write (store).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   inst_sram_*                     fetch port (wr/wstrb/wdata unused)
//   data_sram_*                     load/store port
//   ar*, r*                         AXI read address / data channels
//   aw*, w*, b*                     AXI write address / data / response channels
// Fixed AXI fields (len, burst, lock, cache, prot, wid) are tied off outside.
// Macro SRAM_AXI_BRIDGE_RR_EN: round-robin read arbitration (default fixed
// data-over-inst priority).
module sram_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  wr_state_e   w_state_q, w_state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [3:0]  awid_q, awid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        data_rd_req_s, raw_block_s, wr_accept_s;
  logic        aw_hs_s, w_hs_s, b_hs_s;
  logic        rd_inst_addr_ok_s, rd_data_addr_ok_s;
  logic        rd_inst_data_ok_s, rd_data_data_ok_s;
  logic        unused_inputs_s;

  // Response fields and the fetch port's write fields carry no information here.
  assign unused_inputs_s = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rid, rresp, rlast, bid, bresp};

  // Request decode and the read-after-write hazard against the pending store.
  always_comb begin
    data_rd_req_s = data_sram_req & ~data_sram_wr;
    raw_block_s   = (w_state_q != W_IDLE) && (data_sram_addr[31:2] == awaddr_q[31:2]);
    wr_accept_s   = data_sram_req & data_sram_wr & (w_state_q == W_IDLE) & ~reset;
    aw_hs_s       = awvalid & awready;
    w_hs_s        = wvalid & wready;
    b_hs_s        = bvalid & bready;
  end

  sram_axi_rd_arb #(
    .ID_INST (ID_INST),
    .ID_DATA (ID_DATA)
  ) u_rd_arb (
    .clk_i          (clk),
    .reset_i        (reset),
    .inst_req_i     (inst_sram_req),
    .inst_size_i    (inst_sram_size),
    .inst_addr_i    (inst_sram_addr),
    .data_req_i     (data_rd_req_s),
    .data_size_i    (data_sram_size),
    .data_addr_i    (data_sram_addr),
    .raw_block_i    (raw_block_s),
    .inst_addr_ok_o (rd_inst_addr_ok_s),
    .data_addr_ok_o (rd_data_addr_ok_s),
    .arid_o         (arid),
    .araddr_o       (araddr),
    .arsize_o       (arsize),
    .arvalid_o      (arvalid),
    .arready_i      (arready),
    .rvalid_i       (rvalid),
    .rready_o       (rready),
    .inst_data_ok_o (rd_inst_data_ok_s),
    .data_data_ok_o (rd_data_data_ok_s)
  );

  sram_axi_bridge_chk u_chk (
    .clk_i        (clk),
    .reset_i      (reset),
    .rd_data_ok_i (rd_data_data_ok_s),
    .wr_data_ok_i (b_hs_s)
  );

  // Write FSM state and latched store registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awid_q    <= 4'd0;
      awaddr_q  <= 32'd0;
      awsize_q  <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Write FSM next state; AW and W complete independently in W_REQ.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_accept_s) begin
          w_state_d = W_REQ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awid_d    = ID_DATA;
          awaddr_d  = data_sram_addr;
          awsize_d  = to_axi_size(data_sram_size);
          wdata_d   = data_sram_wdata;
          wstrb_d   = data_sram_wstrb;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_REQ: begin
        aw_done_d = aw_done_q | aw_hs_s;
        w_done_d  = w_done_q | w_hs_s;
        // The last of the two handshakes moves on in the same cycle.
        if (aw_done_d && w_done_d) begin
          w_state_d = W_B;
        end else begin
          w_state_d = W_REQ;
        end
      end
      W_B: begin
        if (bvalid) begin
          w_state_d = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          w_state_d = W_B;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write-channel outputs and merged SRAM-side responses.
  always_comb begin
    awvalid           = (w_state_q == W_REQ) & ~aw_done_q;
    wvalid            = (w_state_q == W_REQ) & ~w_done_q;
    bready            = (w_state_q == W_B);
    awid              = awid_q;
    awaddr            = awaddr_q;
    awsize            = awsize_q;
    wdata             = wdata_q;
    wstrb             = wstrb_q;
    wlast             = 1'b1;
    inst_sram_addr_ok = rd_inst_addr_ok_s;
    inst_sram_data_ok = rd_inst_data_ok_s;
    inst_sram_rdata   = rdata;
    data_sram_addr_ok = rd_data_addr_ok_s | wr_accept_s;
    data_sram_data_ok = rd_data_data_ok_s | (b_hs_s & ~reset);
    data_sram_rdata   = rdata;
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  // Scoreboard queues.
  typedef struct {logic [3:0] id; logic [31:0] addr; logic [2:0] size;} ar_exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [2:0] size;} wr_exp_t;
  typedef struct {logic is_store; logic [31:0] data;} dok_exp_t;
  ar_exp_t     exp_ar_q[$];
  wr_exp_t     exp_wr_q[$];
  logic [31:0] exp_inst_q[$];
  dok_exp_t    exp_dok_q[$];

  function automatic logic [31:0] rmodel(input logic [31:0] a);
    if (a == 32'h1c000000) return 32'h02800c0c;
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  // Slave timing knobs and values sampled at the negedge before each active edge.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic rst_seen, ar_hs_seen, r_hs_seen, aw_hs_seen, w_hs_seen, b_hs_seen;
  logic [3:0] arid_seen, awid_seen;
  logic [31:0] araddr_seen, awaddr_seen, wdata_seen;
  logic [2:0] arsize_seen, awsize_seen;
  logic [3:0] wstrb_seen;
  logic wlast_seen;
  int cyc = 0, last_b_cyc = -10, inst_ok_cnt = 0, data_ok_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rst_seen    <= reset;
    ar_hs_seen  <= arvalid && arready;
    r_hs_seen   <= rvalid && rready;
    aw_hs_seen  <= awvalid && awready;
    w_hs_seen   <= wvalid && wready;
    b_hs_seen   <= bvalid && bready;
    arid_seen   <= arid;   araddr_seen <= araddr; arsize_seen <= arsize;
    awid_seen   <= awid;   awaddr_seen <= awaddr; awsize_seen <= awsize;
    wdata_seen  <= wdata;  wstrb_seen  <= wstrb;  wlast_seen  <= wlast;
    if (bvalid && bready) last_b_cyc <= cyc;
    if (inst_sram_data_ok) begin
      inst_ok_cnt <= inst_ok_cnt + 1;
      if (exp_inst_q.size() == 0) chk("inst_ok_unexpected", 32'd1, 32'd0);
      else chk("inst_rdata", inst_sram_rdata, exp_inst_q.pop_front());
    end
    if (data_sram_data_ok) begin
      data_ok_cnt <= data_ok_cnt + 1;
      if (exp_dok_q.size() == 0) chk("data_ok_unexpected", 32'd1, 32'd0);
      else begin
        if (exp_dok_q[0].is_store) chk("store_ok_on_b", 32'(bvalid && bready), 32'd1);
        else chk("load_rdata", data_sram_rdata, exp_dok_q[0].data);
        void'(exp_dok_q.pop_front());
      end
    end
  end

  // AXI slave model, stepped just after each active edge.
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  logic r_pend, aw_got, w_got, b_pend;
  logic [3:0] cap_id;
  logic [31:0] cap_addr;
  initial begin
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; cap_id = 4'd0; cap_addr = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (rst_seen === 1'b1) begin
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0;
      end else begin
        if (ar_hs_seen) begin
          arready = 1'b0; ar_wait = 0; r_pend = 1'b1; r_wait = 0;
          cap_id = arid_seen; cap_addr = araddr_seen;
          if (exp_ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
          else begin
            chk("arid", 32'(arid_seen), 32'(exp_ar_q[0].id));
            chk("araddr", araddr_seen, exp_ar_q[0].addr);
            chk("arsize", 32'(arsize_seen), 32'(exp_ar_q[0].size));
            void'(exp_ar_q.pop_front());
          end
        end else if (arvalid && !r_pend) begin
          arready = (ar_wait >= ar_dly); ar_wait++;
        end
        if (r_hs_seen) begin
          rvalid = 1'b0; r_pend = 1'b0;
        end else if (r_pend && !rvalid) begin
          if (r_wait >= r_dly) begin rvalid = 1'b1; rid = cap_id; rdata = rmodel(cap_addr); end
          r_wait++;
        end
        if (aw_hs_seen) begin aw_got = 1'b1; awready = 1'b0; end
        else if (awvalid && !aw_got) begin awready = (aw_wait >= aw_dly); aw_wait++; end
        if (w_hs_seen) begin w_got = 1'b1; wready = 1'b0; end
        else if (wvalid && !w_got) begin wready = (w_wait >= w_dly); w_wait++; end
        if ((aw_hs_seen || w_hs_seen) && aw_got && w_got) begin
          b_pend = 1'b1; b_wait = 0;
          if (exp_wr_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
          else begin
            chk("awaddr", awaddr_seen, exp_wr_q[0].addr);
            chk("wdata", wdata_seen, exp_wr_q[0].data);
            chk("wstrb", 32'(wstrb_seen), 32'(exp_wr_q[0].strb));
            chk("awsize", 32'(awsize_seen), 32'(exp_wr_q[0].size));
            chk("awid_wlast", 32'({awid_seen, wlast_seen}), 32'({4'd1, 1'b1}));
            void'(exp_wr_q.pop_front());
          end
        end
        if (b_hs_seen) begin
          bvalid = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
        end else if (b_pend && !bvalid) begin
          if (b_wait >= b_dly) begin bvalid = 1'b1; bid = 4'd1; end
          b_wait++;
        end
      end
    end
  end

  task automatic do_inst(input logic [31:0] a, output int n);
    inst_sram_req = 1'b1; inst_sram_addr = a; inst_sram_size = 2'd2; n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (inst_sram_addr_ok) break;
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) chk("inst_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    inst_sram_req = 1'b0;
  endtask

  task automatic do_data(input logic wr, input logic [3:0] strb, input logic [31:0] a,
                         input logic [31:0] wd, output int n, output int acyc);
    data_sram_req = 1'b1; data_sram_wr = wr; data_sram_size = 2'd2;
    data_sram_wstrb = strb; data_sram_addr = a; data_sram_wdata = wd; n = 0; acyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_sram_addr_ok) begin acyc = cyc; break; end
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) chk("data_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    data_sram_req = 1'b0; data_sram_wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_ar_q.size() == 0 && exp_wr_q.size() == 0 && exp_inst_q.size() == 0 &&
          exp_dok_q.size() == 0 && !(arvalid || rready || awvalid || wvalid || bready)) break;
    end
    if (k >= 300) chk(tag, 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  int n1, n2, a1, a2, ic0, dc0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'd0;
    inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_wstrb = 4'd0;
    data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({arvalid, rready, awvalid, wvalid, bready, inst_sram_addr_ok,
        inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}), 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_awaddr", awaddr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch, arready after two cycles.
    ar_dly = 2; r_dly = 0;
    exp_ar_q.push_back('{4'd0, 32'h1c000000, 3'd2});
    exp_inst_q.push_back(32'h02800c0c);
    do_inst(32'h1c000000, n1);
    chk("t1_accept_cycle", 32'(n1), 32'd0);
    drain("t1_drain_timeout");
    chk("t1_inst_ok_count", 32'(inst_ok_cnt), 32'd1);
    chk("t1_data_ok_count", 32'(data_ok_cnt), 32'd0);

    // Simultaneous fetch and load: load wins.
    ar_dly = 0;
    exp_ar_q.push_back('{4'd1, 32'h200, 3'd2});
    exp_ar_q.push_back('{4'd0, 32'h100, 3'd2});
    exp_dok_q.push_back('{1'b0, rmodel(32'h200)});
    exp_inst_q.push_back(rmodel(32'h100));
    fork
      do_inst(32'h100, n1);
      do_data(1'b0, 4'hf, 32'h200, 32'd0, n2, a2);
    join
    chk("t2_data_accept", 32'(n2), 32'd0);
    chk("t2_inst_after_r", 32'(n1), 32'd3);
    drain("t2_drain_timeout");

    // Lone load, then contention again: round-robin flips the winner.
    exp_ar_q.push_back('{4'd1, 32'h300, 3'd2});
    exp_dok_q.push_back('{1'b0, rmodel(32'h300)});
    do_data(1'b0, 4'hf, 32'h300, 32'd0, n2, a2);
    drain("t2b_drain_timeout");
`ifdef SRAM_AXI_BRIDGE_RR_EN
    exp_ar_q.push_back('{4'd0, 32'h104, 3'd2});
    exp_ar_q.push_back('{4'd1, 32'h204, 3'd2});
`else
    exp_ar_q.push_back('{4'd1, 32'h204, 3'd2});
    exp_ar_q.push_back('{4'd0, 32'h104, 3'd2});
`endif
    exp_dok_q.push_back('{1'b0, rmodel(32'h204)});
    exp_inst_q.push_back(rmodel(32'h104));
    fork
      do_inst(32'h104, n1);
      do_data(1'b0, 4'hf, 32'h204, 32'd0, n2, a2);
    join
`ifdef SRAM_AXI_BRIDGE_RR_EN
    chk("t2c_inst_accept", 32'(n1), 32'd0);
    chk("t2c_data_after_r", 32'(n2), 32'd3);
`else
    chk("t2c_data_accept", 32'(n2), 32'd0);
    chk("t2c_inst_after_r", 32'(n1), 32'd3);
`endif
    drain("t2c_drain_timeout");

    // Store with W ready three cycles before AW.
    aw_dly = 3; w_dly = 0; b_dly = 1;
    dc0 = data_ok_cnt;
    exp_wr_q.push_back('{32'h8, 32'hdeadbeef, 4'b0011, 3'd2});
    exp_dok_q.push_back('{1'b1, 32'd0});
    do_data(1'b1, 4'b0011, 32'h8, 32'hdeadbeef, n1, a1);
    chk("t3_accept", 32'(n1), 32'd0);
    @(negedge clk);
    chk("t3_both_valid", 32'({awvalid, wvalid}), 32'b11);
    @(negedge clk);
    chk("t3_w_dropped", 32'({awvalid, wvalid}), 32'b10);
    drain("t3_drain_timeout");
    chk("t3_store_ok_once", 32'(data_ok_cnt - dc0), 32'd1);

    // Load to the same word while the store waits in W_B.
    aw_dly = 0; w_dly = 0; b_dly = 4;
    exp_wr_q.push_back('{32'h8, 32'h0badf00d, 4'hf, 3'd2});
    exp_dok_q.push_back('{1'b1, 32'd0});
    do_data(1'b1, 4'hf, 32'h8, 32'h0badf00d, n1, a1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bready) break;
    end
    chk("t4_in_wb", 32'(bready), 32'd1);
    @(posedge clk); #1;
    exp_ar_q.push_back('{4'd1, 32'h8, 3'd2});
    exp_dok_q.push_back('{1'b0, rmodel(32'h8)});
    do_data(1'b0, 4'hf, 32'h8, 32'd0, n2, a2);
    chk("t4_load_blocked", 32'(n2 > 0), 32'd1);
    chk("t4_accept_after_b", 32'(a2), 32'(last_b_cyc + 1));
    drain("t4_drain_timeout");

    // Fetch and store overlapping, accepted in the same cycle.
    ar_dly = 1; r_dly = 4; aw_dly = 2; w_dly = 1; b_dly = 1;
    ic0 = inst_ok_cnt; dc0 = data_ok_cnt;
    exp_ar_q.push_back('{4'd0, 32'h1c000040, 3'd2});
    exp_inst_q.push_back(rmodel(32'h1c000040));
    exp_wr_q.push_back('{32'h40, 32'h12345678, 4'hf, 3'd2});
    exp_dok_q.push_back('{1'b1, 32'd0});
    fork
      do_inst(32'h1c000040, n1);
      do_data(1'b1, 4'hf, 32'h40, 32'h12345678, n2, a2);
    join
    chk("t5_inst_accept", 32'(n1), 32'd0);
    chk("t5_store_accept", 32'(n2), 32'd0);
    drain("t5_drain_timeout");
    chk("t5_inst_ok", 32'(inst_ok_cnt - ic0), 32'd1);
    chk("t5_data_ok", 32'(data_ok_cnt - dc0), 32'd1);

    // Reset while in R_R and W_REQ.
    ar_dly = 0; r_dly = 20; aw_dly = 20; w_dly = 20; b_dly = 0;
    exp_ar_q.push_back('{4'd0, 32'h1c000100, 3'd2});
    exp_inst_q.push_back(32'd0);
    exp_wr_q.push_back('{32'h80, 32'h55aa55aa, 4'hf, 3'd2});
    exp_dok_q.push_back('{1'b1, 32'd0});
    fork
      do_inst(32'h1c000100, n1);
      do_data(1'b1, 4'hf, 32'h80, 32'h55aa55aa, n2, a2);
    join
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rready && awvalid) break;
    end
    chk("t6_busy_before_reset", 32'({rready, awvalid}), 32'b11);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_ar_q.delete(); exp_inst_q.delete(); exp_wr_q.delete(); exp_dok_q.delete();
    exp_ar_q.push_back('{4'd0, 32'h1c000200, 3'd2});
    exp_inst_q.push_back(rmodel(32'h1c000200));
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000200; inst_sram_size = 2'd2;
    @(negedge clk);
    chk("t6_ok_gated_in_reset", 32'({inst_sram_addr_ok, data_sram_addr_ok,
        inst_sram_data_ok, data_sram_data_ok}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    r_dly = 0; aw_dly = 0; w_dly = 0;
    @(negedge clk);
    chk("t6_idle_after_reset", 32'({arvalid, rready, awvalid, wvalid, bready,
        inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}), 32'd0);
    chk("t6_accept_first_cycle", 32'(inst_sram_addr_ok), 32'd1);
    @(posedge clk); #1;
    inst_sram_req = 1'b0;
    drain("t6_drain_timeout");
    chk("final_queues_empty", 32'(exp_ar_q.size() + exp_wr_q.size() + exp_inst_q.size() +
        exp_dok_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
